data_bus_responder: RTL and testbench
=====================================

Name: data_bus_responder

Overview:
- Slave end of the CPU data bus: decodes AddressBus/ControlBus, drives DataBusIn, accepts DataBusOut stores.
- Contains a doubleword data RAM plus a small MMIO block: console TX FIFO, FIFO status register and free-running cycle counter.
- Instantiated next to CPU at top level on the same clk.
- Loads are combinational so single-cycle ld completes in one cycle; stores commit on posedge clk.

Parameters:
- WIDTH, 64, bus data/address width (matches BIT_WIDTH).
- RAM_BYTES, 4096, data RAM size in bytes; multiple of 8.
- MMIO_BASE, 64'h0000_0000_0001_0000, base of MMIO window (4 KiB window).
- FIFO_DEPTH, 16, console FIFO entries; power of 2, ≥2.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  WIDTH  byte address (CPU AddressBus).
- wdata  in  WIDTH  store data (CPU DataBusOut).
- ctrl  in  3  CPU ControlBus {MemWriteEn, MemReadEn, RegWriteEn}; bit2 = we, bit1 = re, bit0 ignored.
- rdata  out  WIDTH  load data (to CPU DataBusIn), combinational.
- tx_valid  out  1  console FIFO non-empty.
- tx_data  out  8  FIFO head byte; 0 when empty.
- tx_ready  in  1  consumer accepts head this cycle.
- tx_overflow  out  1  sticky overflow flag.

Behaviour:
- Decode:
  - RAM hit: addr < RAM_BYTES.
  - MMIO hit: MMIO_BASE ≤ addr < MMIO_BASE+0x1000.
  - Anything else unmapped: reads 0, writes ignored.
  - addr[2:0] ignored for all accesses (doubleword aligned); word index = addr >> 3.
- RAM:
  - 64-bit words, little-endian view.
  - Not reset; zero-initialised at time 0 in simulation.
  - Store on posedge clk when we & RAM hit.
  - rdata = word[addr>>3] when re & RAM hit.
- MMIO registers (offset from MMIO_BASE):
  - 0x00 CONSOLE_TX, WO: write pushes wdata[7:0]; reads 0.
  - 0x08 STATUS, RO except bit2:
    - {48'b0, count[7:0], 5'b0, overflow, full, empty}.
    - Writing with wdata[2]=1 clears overflow.
  - 0x10 CYCLE, RO: 64-bit counter, +1 every posedge clk, wraps at 2^64-1 → 0; writes ignored.
  - Other offsets: read 0, write ignored.
- rdata = 0 whenever re = 0.
- we & re together (illegal from CPU): write performed; rdata shows pre-edge contents.
- FIFO:
  - push = we & hit 0x00; pop = tx_valid & tx_ready.
  - Empty: pop impossible; push stores, count → 1, tx_valid high next cycle.
  - Full, push without pop: byte dropped, overflow ← 1 on that edge, count unchanged.
  - Full, push with pop: both accepted, count stays FIFO_DEPTH, no overflow.
  - Otherwise count += push − pop; pointers wrap modulo FIFO_DEPTH.
  - Overflow clear and new overflow in the same cycle: set wins.
- Latency:
  - Load: 0 cycles (combinational).
  - Store/push: visible on the cycle after the edge.
  - STATUS reflects the post-edge count.
- Reset (async): FIFO pointers/count = 0, overflow = 0, CYCLE = 0, tx_valid = 0, tx_data = 0. RAM contents retained. Reset mid-drain discards FIFO contents.
- CPU halt gates its own clock only; CYCLE keeps counting on clk.

Decomposition:
- defs.h (shared): MMIO_BASE, register offsets (CONSOLE_TX, STATUS, CYCLE), ControlBus bit indices (CB_WE = 2, CB_RE = 1, CB_RWE = 0), STATUS bit positions.
- Sub-module console_fifo: sync FIFO with WIDTH = 8, DEPTH; ports push/pop/full/empty/count/head; drop-on-full; push+pop-when-full rule as above. Top decodes and muxes.

Test Plan:
- Reset, then store 64'hDEAD_BEEF_0123_4567 at 0x18 and load 0x18 and 0x1F → both return 64'hDEAD_BEEF_0123_4567; load 0x2000 (unmapped) → 0.
- Write 0x41, 0x42 to MMIO_BASE+0x00 with tx_ready=0 → STATUS = 0x0000_0000_0000_0200; tx_valid=1, tx_data=0x41. Raise tx_ready one cycle → tx_data=0x42, STATUS count = 1.
- Fill FIFO with 16 pushes, push 17th (0x99) with tx_ready=0 → STATUS = 0x1006, tx_overflow=1, 0x99 never appears. Write STATUS with wdata=4 → overflow 0.
- Full FIFO, push 0x55 with tx_ready=1 same cycle → count stays 16, overflow 0, 0x55 is last byte drained.
- Read CYCLE twice, 10 clocks apart → difference 10. Assert rst mid-run → CYCLE=0, tx_valid=0 immediately; a RAM word written before reset still reads back.
- re=0 with RAM-hit addr → rdata=0; we & re on same word → rdata old value, new value read next cycle.

Source files
------------

// File: rtl/data_bus_responder_pkg.sv
// data_bus_responder_pkg: shared ControlBus bit indices, MMIO register map and STATUS packing
package data_bus_responder_pkg;
   localparam int CB_WE  = 2;
   localparam int CB_RE  = 1;
   localparam int CB_RWE = 0;
   localparam logic [63:0] DEF_MMIO_BASE = 64'h0000_0000_0001_0000;
   localparam logic [63:0] MMIO_SPAN     = 64'h0000_0000_0000_1000;
   localparam int ST_OVF_BIT = 2;
   typedef enum logic [8:0] {
      REG_CONSOLE_TX = 9'h000,
      REG_STATUS     = 9'h001,
      REG_CYCLE      = 9'h002
   } mmio_reg_e;
   function automatic logic [63:0] status_word(input logic [7:0] cnt, input logic ovf,
                                               input logic full, input logic empty);
      return {48'b0, cnt, 5'b0, ovf, full, empty};
   endfunction
endpackage

// File: rtl/data_bus_responder_fifo.sv
// console_fifo: byte FIFO that drops pushes when full and keeps a sticky overflow flag
module console_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     i_push,
   input  logic [W-1:0]             i_din,
   input  logic                     i_pop,
   input  logic                     i_clr_ovf,
   output logic [W-1:0]             o_head,
   output logic                     o_full,
   output logic                     o_empty,
   output logic [$clog2(DEPTH):0]   o_count,
   output logic                     o_overflow
);
   localparam int PW = $clog2(DEPTH);
   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wptr, r_rptr;
   logic [PW:0]   r_count;
   logic          r_ovf;
   logic          w_pop, w_push_ok, w_drop;
   assign o_full     = r_count == (PW+1)'(DEPTH);
   assign o_empty    = r_count == '0;
   assign o_count    = r_count;
   assign o_overflow = r_ovf;
   assign o_head     = o_empty ? '0 : r_mem[r_rptr];
   assign w_pop      = i_pop & ~o_empty;
   assign w_push_ok  = i_push & (~o_full | w_pop);
   assign w_drop     = i_push & o_full & ~w_pop;
   // storage is not reset; a full push+pop overwrites the slot being popped this edge
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wptr] <= i_din;
   end
   // pointers, occupancy and overflow; a new overflow beats a same-cycle clear
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
         r_ovf   <= 1'b0;
      end else begin
         r_wptr  <= r_wptr + PW'(w_push_ok);
         r_rptr  <= r_rptr + PW'(w_pop);
         r_count <= r_count + (PW+1)'(w_push_ok) - (PW+1)'(w_pop);
         r_ovf   <= w_drop ? 1'b1 : i_clr_ovf ? 1'b0 : r_ovf;
      end
   end
endmodule

// File: rtl/data_bus_responder.sv
// data_bus_responder: CPU data-bus slave with doubleword RAM, console FIFO and cycle counter
module data_bus_responder
   import data_bus_responder_pkg::*;
#(
   parameter int               WIDTH      = 64,
   parameter int               RAM_BYTES  = 4096,
   parameter logic [WIDTH-1:0] MMIO_BASE  = WIDTH'(DEF_MMIO_BASE),
   parameter int               FIFO_DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [2:0]       ctrl,
   output logic [WIDTH-1:0] rdata,
   output logic             tx_valid,
   output logic [7:0]       tx_data,
   input  logic             tx_ready,
   output logic             tx_overflow
);
   localparam int RAM_WORDS = RAM_BYTES / 8;
   localparam int RAW       = $clog2(RAM_WORDS);
   localparam int CW        = $clog2(FIFO_DEPTH) + 1;
   logic [WIDTH-1:0] r_ram [RAM_WORDS];
   logic [WIDTH-1:0] r_cycle;
   logic [WIDTH-1:0] w_mmio_rd;
   logic [RAW-1:0]   w_ram_idx;
   logic [8:0]       w_reg;
   logic [CW-1:0]    w_count;
   logic             w_we, w_re, w_ram_hit, w_mmio_hit, w_push, w_clr;
   logic             w_full, w_empty;
   logic             w_unused_rwe;
   assign w_we         = ctrl[CB_WE];
   assign w_re         = ctrl[CB_RE];
   assign w_unused_rwe = ctrl[CB_RWE];
   assign w_ram_hit    = addr < WIDTH'(RAM_BYTES);
   assign w_mmio_hit   = (addr >= MMIO_BASE) && (addr < MMIO_BASE + WIDTH'(MMIO_SPAN));
   assign w_ram_idx    = addr[RAW+2:3];
   assign w_reg        = 9'((addr - MMIO_BASE) >> 3);
   assign w_push       = w_we & w_mmio_hit & (w_reg == REG_CONSOLE_TX);
   assign w_clr        = w_we & w_mmio_hit & (w_reg == REG_STATUS) & wdata[ST_OVF_BIT];
   assign tx_valid     = ~w_empty;
   console_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .i_push     (w_push),
      .i_din      (wdata[7:0]),
      .i_pop      (tx_ready),
      .i_clr_ovf  (w_clr),
      .o_head     (tx_data),
      .o_full     (w_full),
      .o_empty    (w_empty),
      .o_count    (w_count),
      .o_overflow (tx_overflow)
   );
   // RAM stores commit on the edge and are never reset
   always_ff @(posedge clk) begin
      if (w_we & w_ram_hit) r_ram[w_ram_idx] <= wdata;
   end
   // free-running cycle counter, wraps naturally at 2^WIDTH
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_cycle <= '0;
      else     r_cycle <= r_cycle + 1'b1;
   end
   // combinational load path; pre-edge contents are shown even during a store
   always_comb begin
      w_mmio_rd = (w_reg == REG_STATUS) ? WIDTH'(status_word(8'(w_count), tx_overflow, w_full, w_empty)) :
                  (w_reg == REG_CYCLE)  ? r_cycle : '0;
      rdata     = ~w_re      ? '0 :
                  w_ram_hit  ? r_ram[w_ram_idx] :
                  w_mmio_hit ? w_mmio_rd : '0;
   end
endmodule

// File: tb/tb_data_bus_responder.sv
// tb_data_bus_responder: randomized bench against a queue/array model plus directed literal checks
module tb_data_bus_responder;
   localparam logic [63:0] BASE = 64'h0000_0000_0001_0000;
   localparam logic [2:0]  IDLE = 3'b000, RD = 3'b010, WR = 3'b100, WRD = 3'b110;
   logic        clk = 1'b0, rst = 1'b1;
   logic [63:0] addr = '0, wdata = '0;
   logic [2:0]  ctrl = '0;
   logic        tx_ready = 1'b0;
   logic [63:0] rdata;
   logic        tx_valid, tx_overflow;
   logic [7:0]  tx_data;
   int          errors = 0, checks = 0;
   logic        run_cmp = 1'b0;
   logic [63:0] m_ram [512];
   logic [7:0]  m_q[$];
   logic        m_ovf = 1'b0;
   logic [63:0] m_cycle = '0;
   logic [63:0] c0, c1;

   always #5 clk = ~clk;

   data_bus_responder dut (
      .clk(clk), .rst(rst), .addr(addr), .wdata(wdata), .ctrl(ctrl), .rdata(rdata),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready), .tx_overflow(tx_overflow)
   );

   function automatic logic is_mmio(input logic [63:0] a);
      return a >= BASE && a < BASE + 64'h1000;
   endfunction

   function automatic logic [63:0] exp_rdata();
      logic [63:0] off;
      if (!ctrl[1]) return '0;
      if (addr < 64'd4096) return m_ram[addr[11:3]];
      if (is_mmio(addr)) begin
         off = (addr - BASE) / 8;
         if (off == 1)
            return 64'(m_q.size()) * 256 + 64'(m_ovf) * 4 + 64'(m_q.size() == 16) * 2 + 64'(m_q.size() == 0);
         if (off == 2) return m_cycle;
      end
      return '0;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic [63:0] a, input logic [63:0] d, input logic [2:0] c, input logic r);
      @(posedge clk);
      #1;
      addr = a; wdata = d; ctrl = c; tx_ready = r;
   endtask

   initial for (int i = 0; i < 512; i++) m_ram[i] = '0;

   // reference model: bus effects applied per edge in plain queue/array terms
   always @(posedge clk or posedge rst) begin
      logic pop, push, drop;
      if (rst) begin
         m_q.delete();
         m_ovf = 1'b0;
         m_cycle = '0;
      end else begin
         pop  = tx_ready && m_q.size() != 0;
         push = ctrl[2] && is_mmio(addr) && (addr - BASE) / 8 == 0;
         drop = push && m_q.size() == 16 && !pop;
         if (ctrl[2] && addr < 64'd4096) m_ram[addr[11:3]] = wdata;
         if (pop) void'(m_q.pop_front());
         if (push && !drop) m_q.push_back(wdata[7:0]);
         if (drop) m_ovf = 1'b1;
         else if (ctrl[2] && is_mmio(addr) && (addr - BASE) / 8 == 1 && wdata[2]) m_ovf = 1'b0;
         m_cycle = m_cycle + 1;
      end
   end

   always @(negedge clk) begin
      if (run_cmp) begin
         chk("rdata", rdata, exp_rdata());
         chk("tx_valid", 64'(tx_valid), 64'(m_q.size() != 0));
         chk("tx_data", 64'(tx_data), m_q.size() != 0 ? 64'(m_q[0]) : 64'h0);
         chk("tx_overflow", 64'(tx_overflow), 64'(m_ovf));
      end
   end

   initial begin
      logic [63:0] a;
      int r;
      repeat (3) @(posedge clk);
      run_cmp = 1'b1;
      @(negedge clk);
      chk("rst_tx_valid", 64'(tx_valid), 64'h0);
      chk("rst_tx_data", 64'(tx_data), 64'h0);
      chk("rst_overflow", 64'(tx_overflow), 64'h0);
      drive(BASE + 16, 0, RD, 0);
      @(negedge clk) chk("rst_cycle", rdata, 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      for (int i = 0; i < 512; i++) drive(64'(i) * 8, 0, WR, 0);
      drive(64'h18, 64'hDEAD_BEEF_0123_4567, WR, 0);
      drive(64'h18, 0, RD, 0);
      @(negedge clk) chk("ld_18", rdata, 64'hDEAD_BEEF_0123_4567);
      drive(64'h1F, 0, RD, 0);
      @(negedge clk) chk("ld_1f", rdata, 64'hDEAD_BEEF_0123_4567);
      drive(64'h2000, 0, RD, 0);
      @(negedge clk) chk("ld_unmapped", rdata, 64'h0);
      drive(BASE, 64'h41, WR, 0);
      drive(BASE, 64'h42, WR, 0);
      drive(BASE + 8, 0, RD, 0);
      @(negedge clk);
      chk("status_two", rdata, 64'h200);
      chk("head_41", 64'(tx_data), 64'h41);
      chk("valid_two", 64'(tx_valid), 64'h1);
      drive(BASE + 8, 0, RD, 1);
      drive(BASE + 8, 0, RD, 0);
      @(negedge clk);
      chk("status_one", rdata, 64'h100);
      chk("head_42", 64'(tx_data), 64'h42);
      drive(0, 0, IDLE, 1);
      drive(0, 0, IDLE, 0);
      @(negedge clk) chk("drained", 64'(tx_valid), 64'h0);
      for (int i = 0; i < 16; i++) drive(BASE, 64'h10 + 64'(i), WR, 0);
      drive(BASE, 64'h99, WR, 0);
      drive(BASE + 8, 0, RD, 0);
      @(negedge clk);
      chk("status_ovf", rdata, 64'h1006);
      chk("ovf_set", 64'(tx_overflow), 64'h1);
      drive(BASE + 8, 64'h4, WR, 0);
      drive(BASE + 8, 0, RD, 0);
      @(negedge clk);
      chk("status_clr", rdata, 64'h1002);
      chk("ovf_clr", 64'(tx_overflow), 64'h0);
      drive(BASE, 64'h55, WR, 1);
      drive(BASE + 8, 0, RD, 0);
      @(negedge clk);
      chk("status_pushpop", rdata, 64'h1002);
      chk("ovf_pushpop", 64'(tx_overflow), 64'h0);
      for (int i = 0; i < 16; i++) begin
         drive(0, 0, IDLE, 1);
         @(negedge clk) chk($sformatf("drain_%0d", i), 64'(tx_data), i < 15 ? 64'h11 + 64'(i) : 64'h55);
      end
      drive(0, 0, IDLE, 0);
      @(negedge clk) chk("empty_after_drain", 64'(tx_valid), 64'h0);
      drive(BASE + 16, 0, RD, 0);
      @(negedge clk) c0 = rdata;
      repeat (10) drive(BASE + 16, 0, RD, 0);
      @(negedge clk) c1 = rdata;
      chk("cycle_delta", c1 - c0, 64'd10);
      drive(64'h40, 64'hCAFE_F00D_1234_5678, WR, 0);
      drive(BASE, 64'h77, WR, 0);
      drive(BASE + 16, 0, RD, 0);
      #2 rst = 1'b1;
      #1;
      chk("rst_mid_valid", 64'(tx_valid), 64'h0);
      chk("rst_mid_cycle", rdata, 64'h0);
      @(posedge clk);
      #1 rst = 1'b0;
      drive(64'h40, 0, RD, 0);
      @(negedge clk) chk("ram_retained", rdata, 64'hCAFE_F00D_1234_5678);
      drive(64'h40, 0, IDLE, 0);
      @(negedge clk) chk("re_low", rdata, 64'h0);
      drive(64'h40, 64'h1111_2222_3333_4444, WRD, 0);
      @(negedge clk) chk("we_re_old", rdata, 64'hCAFE_F00D_1234_5678);
      drive(64'h40, 0, RD, 0);
      @(negedge clk) chk("we_re_new", rdata, 64'h1111_2222_3333_4444);
      repeat (3000) begin
         r = $urandom_range(0, 9);
         if (r < 5)       a = 64'($urandom_range(0, 4095));
         else if (r < 8)  a = BASE + 64'($urandom_range(0, 3) * 8 + $urandom_range(0, 7));
         else if (r == 8) a = ($urandom_range(0, 1) != 0) ? BASE + 64'h1000 + 64'($urandom_range(0, 15)) : BASE - 8;
         else             a = {$urandom, $urandom} | 64'h2000;
         drive(a, {$urandom, $urandom}, 3'($urandom_range(0, 7)), $urandom_range(0, 2) == 0);
      end
      drive(0, 0, IDLE, 0);
      @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
